instr_fetch2_queue: RTL and testbench

INSTR_FETCH2_QUEUE -- requirements
Module: instr_fetch2_queue

---
 rtl/instr_fetch2_queue_if.sv | 40 ++++
 rtl/instr_fetch2_queue.sv | 116 +++++++++++
 tb/tb_instr_fetch2_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch2_queue_if.sv
// Fetch-stage-2 bundle: fetch1 request, icache data-array read port, decode-side output.
// Master drives requests/read data/ready; slave is the fetch2 queue.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

interface instr_fetch2_queue_if #(
   parameter int unsigned FETCH_WIDTH = `FETCH_WIDTH,
   parameter int unsigned INSTR_WIDTH = `INSTR_WIDTH,
   parameter int unsigned PADDR_WIDTH = `PADDR_WIDTH
);
   logic                                      i_req_valid;
   logic                                      o_req_ready;
   logic [PADDR_WIDTH-1:0]                    i_paddr;
   logic [FETCH_WIDTH-1:0][1:0]               i_valids;
   logic                                      i_flush;
   logic                                      o_rd_en;
   logic [PADDR_WIDTH-1:0]                    o_rd_paddr;
   logic [FETCH_WIDTH-1:0][INSTR_WIDTH-1:0]   i_rd_data;
   logic                                      o_valid;
   logic                                      i_ready;
   // fetched_instr_t per slot: {instruction, 2-bit valid code}
   logic [FETCH_WIDTH-1:0][INSTR_WIDTH+1:0]   o_instrs;

   modport master (
      output i_req_valid, i_paddr, i_valids, i_flush, i_rd_data, i_ready,
      input  o_req_ready, o_rd_en, o_rd_paddr, o_valid, o_instrs
   );

   modport slave (
      input  i_req_valid, i_paddr, i_valids, i_flush, i_rd_data, i_ready,
      output o_req_ready, o_rd_en, o_rd_paddr, o_valid, o_instrs
   );
endinterface

// File: rtl/instr_fetch2_queue.sv
// Fetch stage 2: issues icache data reads for accepted groups and queues the returning data.
// Define FETCH2_BYPASS_EN to forward returning data straight to the output when the queue is empty.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef PADDR_WIDTH
`define PADDR_WIDTH 32
`endif

module instr_fetch2_queue #(
   parameter int unsigned FETCH_WIDTH = `FETCH_WIDTH,
   parameter int unsigned INSTR_WIDTH = `INSTR_WIDTH,
   parameter int unsigned PADDR_WIDTH = `PADDR_WIDTH,
   parameter int unsigned DEPTH       = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   instr_fetch2_queue_if.slave  bus
);
   localparam int unsigned SLOT_W = INSTR_WIDTH + 2;
   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned OCC_W  = CNT_W + 1;

   typedef logic [FETCH_WIDTH-1:0][SLOT_W-1:0] group_t;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("instr_fetch2_queue: DEPTH must be a power of 2 and at least 2");
   end

   group_t                    mem [DEPTH];
   logic [PTR_W-1:0]          wr_ptr;
   logic [PTR_W-1:0]          rd_ptr;
   logic [CNT_W-1:0]          count;
   logic                      s1_valid;
   logic [FETCH_WIDTH-1:0][1:0] s1_valids;

   group_t                    s1_group;
   logic [OCC_W-1:0]          occupancy;
   logic                      req_ready;
   logic                      accept;
   logic                      q_nonempty;
   logic                      bypass;
   logic                      push;
   logic                      pop;

   always_comb begin
      s1_group = '0;
      for (int unsigned i = 0; i < FETCH_WIDTH; i++)
         s1_group[i] = {bus.i_rd_data[i], s1_valids[i]};
   end

   // Readiness counts the read still in flight so its returning data always has a free entry.
   assign occupancy  = OCC_W'(count) + OCC_W'(s1_valid);
   assign req_ready  = occupancy < OCC_W'(DEPTH);
   assign accept     = bus.i_req_valid && req_ready && !bus.i_flush && !i_rst;
   assign q_nonempty = (count != '0);

`ifdef FETCH2_BYPASS_EN
   assign bypass = !q_nonempty && s1_valid && !bus.i_flush;
   assign push   = s1_valid && !bus.i_flush && !(bypass && bus.i_ready);
`else
   assign bypass = 1'b0;
   assign push   = s1_valid && !bus.i_flush;
`endif

   assign pop = q_nonempty && !bus.i_flush && bus.i_ready;

   assign bus.o_req_ready = req_ready;
   assign bus.o_rd_en     = accept;
   assign bus.o_rd_paddr  = bus.i_paddr;
   assign bus.o_valid     = (q_nonempty || bypass) && !bus.i_flush;

   always_comb begin
      bus.o_instrs = '0;
      if (q_nonempty)
         bus.o_instrs = mem[rd_ptr];
      else if (bypass)
         bus.o_instrs = s1_group;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count     <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         s1_valid  <= 1'b0;
         s1_valids <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (bus.i_flush) begin
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept)
            s1_valids <= bus.i_valids;
         if (push) begin
            mem[wr_ptr] <= s1_group;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch2_queue.sv
// Directed bench for instr_fetch2_queue: reset, stream, backpressure, flush, mid-run reset, wrap.
// Also models the icache data array (data returns one cycle after o_rd_en).
module tb_instr_fetch2_queue;
   localparam int unsigned FW = 4;
   localparam int unsigned IW = 32;
   localparam int unsigned PW = 32;
   localparam int unsigned D  = 2;

   typedef logic [FW-1:0][IW+1:0] grp_t;
   typedef logic [FW-1:0][IW-1:0] data_t;
   typedef logic [FW-1:0][1:0]    vld_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch2_queue_if #(.FETCH_WIDTH(FW), .INSTR_WIDTH(IW), .PADDR_WIDTH(PW)) bus ();

   instr_fetch2_queue #(.FETCH_WIDTH(FW), .INSTR_WIDTH(IW), .PADDR_WIDTH(PW), .DEPTH(D)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int unsigned n_tests;
   int unsigned n_fail;

   // Slot i valid code rotates with paddr[5:4] so every group contains one all-zero code.
   function automatic vld_t vcode(input logic [PW-1:0] pa);
      vld_t v;
      for (int i = 0; i < FW; i++) v[i] = 2'(pa[5:4] + 2'(i));
      return v;
   endfunction

   function automatic data_t rdgrp(input logic [PW-1:0] pa);
      data_t d;
      for (int i = 0; i < FW; i++) d[i] = {16'hCAFE, pa[11:0], 4'(i)};
      return d;
   endfunction

   function automatic grp_t exp_grp(input logic [PW-1:0] pa);
      grp_t  g;
      data_t d;
      vld_t  v;
      d = rdgrp(pa);
      v = vcode(pa);
      for (int i = 0; i < FW; i++) g[i] = {d[i], v[i]};
      return g;
   endfunction

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_grp(input string tag, input grp_t obs, input grp_t exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [PW-1:0] pa);
      bus.i_req_valid = v;
      bus.i_paddr     = pa;
      bus.i_valids    = vcode(pa);
   endtask

   // Advance one clock; leaves time at edge+1 with the icache return data driven.
   task automatic tick();
      logic           en;
      logic [PW-1:0]  pa;
      #1;
      en = bus.o_rd_en;
      pa = bus.o_rd_paddr;
      @(posedge clk);
      #1;
      bus.i_rd_data = en ? rdgrp(pa) : '0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk_bit({tag, "_req_ready"}, bus.o_req_ready, 1'b1);
      chk_bit({tag, "_valid"},     bus.o_valid,     1'b0);
      chk_bit({tag, "_rd_en"},     bus.o_rd_en,     1'b0);
      chk_grp({tag, "_instrs"},    bus.o_instrs,    '0);
   endtask

   int unsigned s_req  [7];
   logic        s_rden [7];
   logic        s_vld  [7];
   int unsigned s_out  [7];
   int unsigned k, j;

   initial begin
      n_tests = 0;
      n_fail  = 0;
`ifdef FETCH2_BYPASS_EN
      s_req  = '{'h100, 'h110, 'h120, 0, 0, 0, 0};
      s_rden = '{1, 1, 1, 0, 0, 0, 0};
      s_vld  = '{0, 1, 1, 1, 0, 0, 0};
      s_out  = '{0, 'h100, 'h110, 'h120, 0, 0, 0};
`else
      s_req  = '{'h100, 'h110, 'h120, 'h120, 0, 0, 0};
      s_rden = '{1, 1, 0, 1, 0, 0, 0};
      s_vld  = '{0, 0, 1, 1, 0, 1, 0};
      s_out  = '{0, 0, 'h100, 'h110, 0, 'h120, 0};
`endif
      rst = 1'b1;
      bus.i_flush   = 1'b0;
      bus.i_ready   = 1'b0;
      bus.i_rd_data = '0;
      drive(1'b1, 32'h100);
      tick();
      tick();
      #1;
      chk_idle_outputs("reset");
      rst = 1'b0;
      drive(1'b0, 32'h0);
      tick();

      // Stream with i_ready held high; requests held until accepted
      bus.i_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drive(s_req[c] != 0, s_req[c]);
         #1;
         chk_bit($sformatf("stream_rd_en_c%0d", c), bus.o_rd_en, s_rden[c]);
         if (s_rden[c]) chk_val($sformatf("stream_rd_paddr_c%0d", c), bus.o_rd_paddr, s_req[c]);
         chk_bit($sformatf("stream_valid_c%0d", c), bus.o_valid, s_vld[c]);
         chk_grp($sformatf("stream_instrs_c%0d", c), bus.o_instrs, s_vld[c] ? exp_grp(s_out[c]) : '0);
         tick();
      end

      // Backpressure: two accepts then o_req_ready drops
      bus.i_ready = 1'b0;
      drive(1'b1, 32'h100); #1;
      chk_bit("bp_rd_en_0", bus.o_rd_en, 1'b1);
      tick();
      drive(1'b1, 32'h110); #1;
      chk_bit("bp_rd_en_1", bus.o_rd_en, 1'b1);
`ifdef FETCH2_BYPASS_EN
      chk_bit("bp_valid_1", bus.o_valid, 1'b1);
`else
      chk_bit("bp_valid_1", bus.o_valid, 1'b0);
`endif
      tick();
      drive(1'b1, 32'h120); #1;
      chk_bit("bp_req_ready_2", bus.o_req_ready, 1'b0);
      chk_bit("bp_rd_en_2", bus.o_rd_en, 1'b0);
      chk_grp("bp_instrs_2", bus.o_instrs, exp_grp(32'h100));
      tick(); #1;
      chk_bit("bp_req_ready_3", bus.o_req_ready, 1'b0);
      chk_grp("bp_instrs_3", bus.o_instrs, exp_grp(32'h100));
      tick();
      bus.i_ready = 1'b1; #1;
      chk_bit("bp_valid_4", bus.o_valid, 1'b1);
      chk_grp("bp_instrs_4", bus.o_instrs, exp_grp(32'h100));
      chk_bit("bp_req_ready_4", bus.o_req_ready, 1'b0);
      tick(); #1;
      chk_grp("bp_instrs_5", bus.o_instrs, exp_grp(32'h110));
      chk_bit("bp_req_ready_5", bus.o_req_ready, 1'b1);
      chk_bit("bp_rd_en_5", bus.o_rd_en, 1'b1);
      tick();
      drive(1'b0, 32'h0); #1;
`ifdef FETCH2_BYPASS_EN
      chk_grp("bp_instrs_6", bus.o_instrs, exp_grp(32'h120));
      tick(); #1;
      chk_bit("bp_valid_7", bus.o_valid, 1'b0);
`else
      chk_bit("bp_valid_6", bus.o_valid, 1'b0);
      tick(); #1;
      chk_grp("bp_instrs_7", bus.o_instrs, exp_grp(32'h120));
`endif
      tick(); #1;
      chk_bit("bp_drained", bus.o_valid, 1'b0);
      tick();

      // Flush with one group queued and one read in flight
      bus.i_ready = 1'b0;
      drive(1'b1, 32'h300); tick();
      drive(1'b1, 32'h310); tick();
      drive(1'b1, 32'h320);
      bus.i_flush = 1'b1; #1;
      chk_bit("flush_valid_0", bus.o_valid, 1'b0);
      chk_bit("flush_rd_en_0", bus.o_rd_en, 1'b0);
      tick();
      bus.i_flush = 1'b0;
      drive(1'b0, 32'h0); #1;
      chk_bit("flush_valid_1", bus.o_valid, 1'b0);
      chk_bit("flush_req_ready_1", bus.o_req_ready, 1'b1);
      chk_grp("flush_instrs_1", bus.o_instrs, '0);
      tick(); #1;
      chk_bit("flush_valid_2", bus.o_valid, 1'b0);
      tick();

      // Asynchronous reset mid-operation
      drive(1'b1, 32'h400); tick();
      drive(1'b1, 32'h410); tick();
      drive(1'b1, 32'h420);
      #2 rst = 1'b1;
      #1;
      chk_idle_outputs("midrst");
      tick();
      rst = 1'b0;
      drive(1'b0, 32'h0); #1;
      chk_bit("midrst_rel_req_ready", bus.o_req_ready, 1'b1);
      chk_bit("midrst_rel_valid", bus.o_valid, 1'b0);
      tick(); #1;
      chk_bit("midrst_dropped", bus.o_valid, 1'b0);
      tick();

      // Ten groups, i_ready toggling, across pointer wrap
      k = 0;
      j = 0;
      for (int c = 0; c < 100 && j < 10; c++) begin
         bus.i_ready = (c % 2 == 0);
         drive(k < 10, 32'h500 + 32'(16 * k));
         #1;
         if (bus.o_rd_en) k++;
         if (bus.o_valid && bus.i_ready) begin
            chk_grp($sformatf("wrap_group_%0d", j), bus.o_instrs, exp_grp(32'h500 + 32'(16 * j)));
            j++;
         end
         tick();
      end
      chk_val("wrap_groups_seen", j, 32'd10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
